mips_id_stage_decoder: RTL and testbench

// - MIPS64 instruction-decode pipeline stage, between IF and EX.
// - Decodes the 32-bit inst into control fields and selects the destination register (3:1 mux).
// - Forwards WB data onto the A/B operands (2:1 muxes) and computes branch/jump targets.
// - Registers all results into the ID pipeline register; the regfile is external, read via rs/rt.

---
 rtl/mips_id_stage_decoder.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mips_id_stage_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_id_stage_decoder.sv
// MIPS64 ID stage: decodes inst, forwards WB data onto A/B, computes branch/jump targets, registers into the ID latch.
// Optional feature: define ID_TRACE_EN for a simulation-only writeback / reserved-instruction trace.
module mips_id_stage_decoder #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc4,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] A_rf,
  input  logic [XLEN-1:0] B_rf,
  input  logic            wb_en,
  input  logic [4:0]      wb_regnum,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic            B_is_reg,
  output logic [4:0]      id_W_regnum,
  output logic [2:0]      id_alu_op,
  output logic            id_write_enable,
  output logic [1:0]      id_alu_src2,
  output logic [1:0]      id_control_type,
  output logic [1:0]      id_mem_load,
  output logic [1:0]      id_mem_store,
  output logic            id_signed_load,
  output logic            id_lui,
  output logic            id_linkpc,
  output logic            id_slt,
  output logic            id_beq,
  output logic            id_bne,
  output logic            id_syscall,
  output logic            id_reserved,
  output logic [XLEN-1:0] id_A_data,
  output logic [XLEN-1:0] id_B_data,
  output logic [XLEN-1:0] id_branch_target,
  output logic [XLEN-1:0] id_jump_target,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [31:0]     id_inst
);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE     = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C,
    OP_ORI     = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F, OP_DADDIU = 6'h19,
    OP_LB      = 6'h20, OP_LW    = 6'h23, OP_LBU   = 6'h24, OP_SB   = 6'h28,
    OP_SW      = 6'h2B, OP_LD    = 6'h37, OP_SD    = 6'h3F
  } opcode_e;

  typedef enum logic [5:0] {
    F_JR   = 6'h08, F_SYSCALL = 6'h0C, F_ADD  = 6'h20, F_ADDU = 6'h21,
    F_SUB  = 6'h22, F_SUBU    = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
    F_XOR  = 6'h26, F_NOR     = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B,
    F_DADD = 6'h2C, F_DADDU   = 6'h2D
  } funct_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0, ALU_ADD = 3'd2, ALU_SUB = 3'd3, ALU_AND = 3'd4,
    ALU_OR   = 3'd5, ALU_NOR = 3'd6, ALU_XOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {SRC2_B = 2'd0, SRC2_SEXT = 2'd1, SRC2_ZEXT = 2'd2} src2_e;
  typedef enum logic [1:0] {CT_PC4 = 2'd0, CT_BRANCH = 2'd1, CT_JR = 2'd2, CT_JUMP = 2'd3} ctrl_e;
  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_BYTE = 2'd1, MEM_WORD = 2'd2, MEM_DWORD = 2'd3} mem_e;
  typedef enum logic [1:0] {RD_RD = 2'd0, RD_RT = 2'd1, RD_R31 = 2'd2} rd_src_e;

  typedef struct packed {
    logic [4:0]      W_regnum;
    alu_op_e         alu_op;
    logic            write_enable;
    src2_e           alu_src2;
    ctrl_e           control_type;
    mem_e            mem_load;
    mem_e            mem_store;
    logic            signed_load;
    logic            lui;
    logic            linkpc;
    logic            slt;
    logic            beq;
    logic            bne;
    logic            syscall;
    logic            reserved;
    logic [XLEN-1:0] A_data;
    logic [XLEN-1:0] B_data;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     inst;
  } id_reg_t;

  logic [5:0] opcode;
  logic [5:0] funct;

  alu_op_e alu_op;
  src2_e   src2;
  ctrl_e   ctrl;
  mem_e    ld;
  mem_e    st;
  rd_src_e rd_src;
  logic    we, sload, is_lui, link, slt, is_beq, is_bne, sys, rsv, b_reg;

  logic [4:0]      w_regnum;
  logic            fwd_a, fwd_b;
  logic [XLEN-1:0] a_val, b_fwd, b_val;
  logic [XLEN-1:0] br_target, j_target;

  id_reg_t id_d, id_q;

  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign B_is_reg = b_reg;

  always_comb begin
    alu_op = ALU_NONE;
    src2   = SRC2_B;
    ctrl   = CT_PC4;
    ld     = MEM_NONE;
    st     = MEM_NONE;
    rd_src = RD_RD;
    we     = 1'b0;
    sload  = 1'b0;
    is_lui = 1'b0;
    link   = 1'b0;
    slt    = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    sys    = 1'b0;
    rsv    = 1'b0;
    b_reg  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        b_reg = 1'b1;
        we    = 1'b1;
        case (funct)
          F_ADD, F_ADDU, F_DADD, F_DADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU:                  alu_op = ALU_SUB;
          F_AND:                          alu_op = ALU_AND;
          F_OR:                           alu_op = ALU_OR;
          F_NOR:                          alu_op = ALU_NOR;
          F_XOR:                          alu_op = ALU_XOR;
          F_SLT, F_SLTU: begin
            alu_op = ALU_SUB;
            slt    = 1'b1;
          end
          F_JR: begin
            ctrl = CT_JR;
            we   = 1'b0;
          end
          F_SYSCALL: begin
            sys = 1'b1;
            we  = 1'b0;
          end
          default: begin
            rsv   = 1'b1;
            we    = 1'b0;
            b_reg = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_DADDIU: begin
        alu_op = ALU_ADD;
        src2   = SRC2_SEXT;
        rd_src = RD_RT;
        we     = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        alu_op = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
        src2   = SRC2_ZEXT;
        rd_src = RD_RT;
        we     = 1'b1;
      end
      OP_LUI: begin
        is_lui = 1'b1;
        src2   = SRC2_ZEXT;
        rd_src = RD_RT;
        we     = 1'b1;
      end
      OP_LB, OP_LBU, OP_LW, OP_LD: begin
        alu_op = ALU_ADD;
        src2   = SRC2_SEXT;
        rd_src = RD_RT;
        we     = 1'b1;
        sload  = (opcode == OP_LB);
        ld     = (opcode == OP_LW) ? MEM_WORD : (opcode == OP_LD) ? MEM_DWORD : MEM_BYTE;
      end
      OP_SB, OP_SW, OP_SD: begin
        alu_op = ALU_ADD;
        src2   = SRC2_SEXT;
        rd_src = RD_RT;
        b_reg  = 1'b1;
        st     = (opcode == OP_SW) ? MEM_WORD : (opcode == OP_SD) ? MEM_DWORD : MEM_BYTE;
      end
      OP_BEQ, OP_BNE: begin
        alu_op = ALU_SUB;
        ctrl   = CT_BRANCH;
        rd_src = RD_RT;
        b_reg  = 1'b1;
        is_beq = (opcode == OP_BEQ);
        is_bne = (opcode == OP_BNE);
      end
      OP_J: ctrl = CT_JUMP;
      OP_JAL: begin
        ctrl   = CT_JUMP;
        rd_src = RD_R31;
        link   = 1'b1;
        we     = 1'b1;
      end
      default: rsv = 1'b1;
    endcase
  end

  always_comb begin
    case (rd_src)
      RD_RT:   w_regnum = rt;
      RD_R31:  w_regnum = 5'd31;
      default: w_regnum = inst[15:11];
    endcase
  end

  // $0 is hardwired, so a writeback to it must never be forwarded.
  assign fwd_a = wb_en && (wb_regnum == rs) && (rs != '0);
  assign fwd_b = b_reg && wb_en && (wb_regnum == rt) && (rt != '0);
  assign a_val = fwd_a ? wb_data : A_rf;
  assign b_fwd = fwd_b ? wb_data : B_rf;
  assign b_val = (sys || rsv) ? {{(XLEN-32){1'b0}}, inst} : b_fwd;

  assign br_target = pc4 + {{(XLEN-18){inst[15]}}, inst[15:0], 2'b00};
  assign j_target  = {pc[XLEN-1:28], inst[25:0], 2'b00};

  always_comb begin
    id_d               = '0;
    id_d.W_regnum      = w_regnum;
    id_d.alu_op        = alu_op;
    id_d.write_enable  = we;
    id_d.alu_src2      = src2;
    id_d.control_type  = ctrl;
    id_d.mem_load      = ld;
    id_d.mem_store     = st;
    id_d.signed_load   = sload;
    id_d.lui           = is_lui;
    id_d.linkpc        = link;
    id_d.slt           = slt;
    id_d.beq           = is_beq;
    id_d.bne           = is_bne;
    id_d.syscall       = sys;
    id_d.reserved      = rsv;
    id_d.A_data        = a_val;
    id_d.B_data        = b_val;
    id_d.branch_target = br_target;
    id_d.jump_target   = j_target;
    id_d.pc            = pc;
    id_d.pc4           = pc4;
    id_d.inst          = inst;
  end

  // A bubble still captures pc so a later exception can report it as EPC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q <= '0;
    end else if (stall || flush) begin
      id_q    <= '0;
      id_q.pc <= pc;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_W_regnum      = id_q.W_regnum;
  assign id_alu_op        = id_q.alu_op;
  assign id_write_enable  = id_q.write_enable;
  assign id_alu_src2      = id_q.alu_src2;
  assign id_control_type  = id_q.control_type;
  assign id_mem_load      = id_q.mem_load;
  assign id_mem_store     = id_q.mem_store;
  assign id_signed_load   = id_q.signed_load;
  assign id_lui           = id_q.lui;
  assign id_linkpc        = id_q.linkpc;
  assign id_slt           = id_q.slt;
  assign id_beq           = id_q.beq;
  assign id_bne           = id_q.bne;
  assign id_syscall       = id_q.syscall;
  assign id_reserved      = id_q.reserved;
  assign id_A_data        = id_q.A_data;
  assign id_B_data        = id_q.B_data;
  assign id_branch_target = id_q.branch_target;
  assign id_jump_target   = id_q.jump_target;
  assign id_pc            = id_q.pc;
  assign id_pc4           = id_q.pc4;
  assign id_inst          = id_q.inst;

`ifdef ID_TRACE_EN
  always @(posedge clock) begin
    if (!reset && wb_en)
      $display("writeback regnum=%0d data=%h", wb_regnum, wb_data);
    if (!reset && rsv)
      $display("reserved opcode=%h inst=%h", opcode, inst);
  end
`else
`endif

endmodule

// File: tb/tb_mips_id_stage_decoder.sv
// Randomized bench for mips_id_stage_decoder: an instruction-semantics model predicts the ID latch every cycle.
module tb_mips_id_stage_decoder;
  localparam int unsigned XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc, pc4, A_rf, B_rf, wb_data;
  logic            stall, flush, wb_en;
  logic [4:0]      wb_regnum;

  logic [4:0]      rs, rt, id_W_regnum;
  logic            B_is_reg, id_write_enable, id_signed_load, id_lui, id_linkpc, id_slt;
  logic            id_beq, id_bne, id_syscall, id_reserved;
  logic [2:0]      id_alu_op;
  logic [1:0]      id_alu_src2, id_control_type, id_mem_load, id_mem_store;
  logic [XLEN-1:0] id_A_data, id_B_data, id_branch_target, id_jump_target, id_pc, id_pc4;
  logic [31:0]     id_inst;

  always #5 clock = ~clock;

  mips_id_stage_decoder #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .inst(inst), .pc(pc), .pc4(pc4),
    .stall(stall), .flush(flush), .A_rf(A_rf), .B_rf(B_rf),
    .wb_en(wb_en), .wb_regnum(wb_regnum), .wb_data(wb_data),
    .rs(rs), .rt(rt), .B_is_reg(B_is_reg),
    .id_W_regnum(id_W_regnum), .id_alu_op(id_alu_op), .id_write_enable(id_write_enable),
    .id_alu_src2(id_alu_src2), .id_control_type(id_control_type),
    .id_mem_load(id_mem_load), .id_mem_store(id_mem_store),
    .id_signed_load(id_signed_load), .id_lui(id_lui), .id_linkpc(id_linkpc),
    .id_slt(id_slt), .id_beq(id_beq), .id_bne(id_bne), .id_syscall(id_syscall),
    .id_reserved(id_reserved), .id_A_data(id_A_data), .id_B_data(id_B_data),
    .id_branch_target(id_branch_target), .id_jump_target(id_jump_target),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst)
  );

  typedef struct packed {
    logic [4:0]  W; logic [2:0] alu; logic we; logic [1:0] src2; logic [1:0] ctrl;
    logic [1:0]  ld; logic [1:0] st; logic sl, lui, link, slt, beq, bne, sys, rsv;
    logic [63:0] A, B, bt, jt, pc, pc4; logic [31:0] inst;
  } idv_t;

  idv_t act, exp_q;
  assign act = {id_W_regnum, id_alu_op, id_write_enable, id_alu_src2, id_control_type,
                id_mem_load, id_mem_store, id_signed_load, id_lui, id_linkpc, id_slt,
                id_beq, id_bne, id_syscall, id_reserved, id_A_data, id_B_data,
                id_branch_target, id_jump_target, id_pc, id_pc4, id_inst};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [5:0] op_list [18] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                               6'h0F, 6'h19, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B, 6'h37, 6'h3F};
  logic [5:0] fn_list [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h08, 6'h0C};

  // Instructions that read rt as a source operand.
  function automatic logic model_breg(input logic [31:0] i);
    logic [5:0] op = i[31:26];
    logic [5:0] fn = i[5:0];
    if (op == 6'h00)
      return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h08, 6'h0C};
    return op inside {6'h28, 6'h2B, 6'h3F, 6'h04, 6'h05};
  endfunction

  function automatic idv_t model_id();
    idv_t        e = '0;
    logic [5:0]  op = inst[31:26];
    logic [5:0]  fn = inst[5:0];
    logic [4:0]  s = inst[25:21];
    logic [4:0]  t = inst[20:16];
    logic        breg = model_breg(inst);
    longint      off = longint'($signed(inst[15:0]));
    e.W = inst[15:11];
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21, 6'h2C, 6'h2D: e.alu = 3'd2;
        6'h22, 6'h23:               e.alu = 3'd3;
        6'h24: e.alu = 3'd4;
        6'h25: e.alu = 3'd5;
        6'h27: e.alu = 3'd6;
        6'h26: e.alu = 3'd7;
        6'h2A, 6'h2B: begin e.alu = 3'd3; e.slt = 1'b1; end
        6'h08: e.ctrl = 2'd2;
        6'h0C: e.sys = 1'b1;
        default: e.rsv = 1'b1;
      endcase
      e.we = !(e.rsv || fn == 6'h08 || fn == 6'h0C);
    end else begin
      case (op)
        6'h08, 6'h09, 6'h19: begin e.alu = 3'd2; e.src2 = 2'd1; e.we = 1'b1; end
        6'h0C: begin e.alu = 3'd4; e.src2 = 2'd2; e.we = 1'b1; end
        6'h0D: begin e.alu = 3'd5; e.src2 = 2'd2; e.we = 1'b1; end
        6'h0E: begin e.alu = 3'd7; e.src2 = 2'd2; e.we = 1'b1; end
        6'h0F: begin e.lui = 1'b1; e.src2 = 2'd2; e.we = 1'b1; end
        6'h20: begin e.alu = 3'd2; e.src2 = 2'd1; e.we = 1'b1; e.ld = 2'd1; e.sl = 1'b1; end
        6'h24: begin e.alu = 3'd2; e.src2 = 2'd1; e.we = 1'b1; e.ld = 2'd1; end
        6'h23: begin e.alu = 3'd2; e.src2 = 2'd1; e.we = 1'b1; e.ld = 2'd2; end
        6'h37: begin e.alu = 3'd2; e.src2 = 2'd1; e.we = 1'b1; e.ld = 2'd3; end
        6'h28: begin e.alu = 3'd2; e.src2 = 2'd1; e.st = 2'd1; end
        6'h2B: begin e.alu = 3'd2; e.src2 = 2'd1; e.st = 2'd2; end
        6'h3F: begin e.alu = 3'd2; e.src2 = 2'd1; e.st = 2'd3; end
        6'h04: begin e.alu = 3'd3; e.ctrl = 2'd1; e.beq = 1'b1; end
        6'h05: begin e.alu = 3'd3; e.ctrl = 2'd1; e.bne = 1'b1; end
        6'h02: e.ctrl = 2'd3;
        6'h03: begin e.ctrl = 2'd3; e.link = 1'b1; e.we = 1'b1; end
        default: e.rsv = 1'b1;
      endcase
      if (op == 6'h03) e.W = 5'd31;
      else if (op != 6'h02 && !e.rsv) e.W = t;
    end
    e.A = (wb_en && wb_regnum == s && s != 0) ? wb_data : A_rf;
    if (e.sys || e.rsv) e.B = 64'(inst);
    else e.B = (breg && wb_en && wb_regnum == t && t != 0) ? wb_data : B_rf;
    e.bt   = pc4 + 64'(off * 4);
    e.jt   = (pc & ~64'h0FFF_FFFF) | (64'(inst[25:0]) << 2);
    e.pc   = pc;
    e.pc4  = pc4;
    e.inst = inst;
    if (stall || flush) begin
      e    = '0;
      e.pc = pc;
    end
    return e;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) exp_q <= '0;
    else       exp_q <= model_id();
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic check_reg();
    n_vec++;
    if (act !== exp_q) begin
      n_bad++;
      $display("FAIL idreg got=%h want=%h", act, exp_q);
    end
  endtask

  task automatic check_comb();
    n_vec++;
    if ({rs, rt, B_is_reg} !== {inst[25:21], inst[20:16], model_breg(inst)}) begin
      n_bad++;
      $display("FAIL comb got=%h want=%h", {rs, rt, B_is_reg},
               {inst[25:21], inst[20:16], model_breg(inst)});
    end
  endtask

  task automatic cycle();
    #1;
    check_comb();
    @(posedge clock);
    #1;
    check_reg();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i = $urandom;
    int unsigned p = $urandom_range(0, 9);
    if (p < 3) begin
      i[31:26] = 6'h00;
      i[5:0]   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 13)];
    end else if (p < 9) begin
      i[31:26] = op_list[$urandom_range(0, 17)];
    end
    i[25:21] = 5'($urandom_range(0, 7));
    i[20:16] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin
    reset = 1'b1; inst = 32'h0; pc = '0; pc4 = '0; stall = 1'b0; flush = 1'b0;
    A_rf = '0; B_rf = '0; wb_en = 1'b0; wb_regnum = '0; wb_data = '0;
    cycle();
    cycle();
    chk("rst_we", 64'(id_write_enable), 64'd0);
    reset = 1'b0;

    // Load something, then assert reset between edges.
    inst = 32'h0085_1020; pc = 64'h2000; pc4 = 64'h2004;
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", 64'(id_write_enable), 64'd0);
    chk("async_rst_pc", id_pc, 64'd0);
    chk("async_rst_w", 64'(id_W_regnum), 64'd0);
    check_reg();
    cycle();
    reset = 1'b0;

    inst = 32'h0085_1020; A_rf = 64'h11; B_rf = 64'h22;
    cycle();
    chk("add_w", 64'(id_W_regnum), 64'd2);
    chk("add_alu", 64'(id_alu_op), 64'd2);
    chk("add_we", 64'(id_write_enable), 64'd1);
    chk("add_src2", 64'(id_alu_src2), 64'd0);

    inst = 32'h2528_FFFC;
    #1;
    chk("addiu_rs", 64'(rs), 64'd9);
    chk("addiu_breg", 64'(B_is_reg), 64'd0);
    cycle();
    chk("addiu_w", 64'(id_W_regnum), 64'd8);
    chk("addiu_src2", 64'(id_alu_src2), 64'd1);

    inst = 32'h1085_0003; pc = 64'h1000; pc4 = 64'h1004;
    cycle();
    chk("beq_bt", id_branch_target, 64'h1010);
    chk("beq_ct", 64'(id_control_type), 64'd1);
    chk("beq_we", 64'(id_write_enable), 64'd0);

    inst = 32'h0C00_0040;
    cycle();
    chk("jal_jt", id_jump_target, 64'h100);
    chk("jal_w", 64'(id_W_regnum), 64'd31);
    chk("jal_link", 64'(id_linkpc), 64'd1);

    inst = 32'h0085_1020; wb_en = 1'b1; wb_regnum = 5'd4; wb_data = 64'hDEAD; A_rf = 64'h1;
    cycle();
    chk("fwd_a", id_A_data, 64'hDEAD);
    inst = 32'h0005_1020; wb_regnum = 5'd0;
    cycle();
    chk("fwd_r0", id_A_data, 64'h1);
    wb_en = 1'b0;

    inst = 32'h7C00_0000; B_rf = 64'h1234;
    cycle();
    chk("rsv_flag", 64'(id_reserved), 64'd1);
    chk("rsv_b", id_B_data, 64'h7C00_0000);
    chk("rsv_we", 64'(id_write_enable), 64'd0);

    inst = 32'h0085_1020; stall = 1'b1; pc = 64'hABC0; pc4 = 64'hABC4;
    cycle();
    chk("stall_we", 64'(id_write_enable), 64'd0);
    chk("stall_inst", 64'(id_inst), 64'd0);
    chk("stall_pc", id_pc, 64'hABC0);
    stall = 1'b0; flush = 1'b1; pc = 64'hBEE0;
    cycle();
    chk("flush_a", id_A_data, 64'd0);
    chk("flush_pc", id_pc, 64'hBEE0);
    flush = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      inst      = rand_inst();
      pc        = {$urandom, $urandom} & ~64'h3;
      pc4       = pc + 64'd4;
      A_rf      = {$urandom, $urandom};
      B_rf      = {$urandom, $urandom};
      wb_en     = 1'($urandom);
      wb_regnum = 5'($urandom_range(0, 7));
      wb_data   = {$urandom, $urandom};
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
